// File: rtl/rst_ctrl_pkg.sv
// Shared state encodings and elaboration helpers for the reset generator.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STRETCH   = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  // Bits needed to count up to v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer with an asynchronous clear/set to a fixed value.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] stages_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) stages_q <= {STAGES{RST_VAL}};
    else       stages_q <= {stages_q[STAGES-2:0], d_i};
  end

  assign q_o = stages_q[STAGES-1];

endmodule

// File: rtl/rst_ctrl_gen.sv
// Reset generator: async-assert / sync-deassert reset gated on filtered PLL lock
// plus a stretch interval, with a level-sensitive software reset request.
module rst_ctrl_gen
  import rst_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pll_lock,
  input  logic       ext_rst_req,
  output logic       rst_out,
  output logic       rst_n_out,
  output logic       ready,
  output logic [1:0] rst_state,
  output logic       lock_lost
);

  localparam int CNT_MAX = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;

  if (CNT_W < clog2(CNT_MAX)) begin : g_bad_cnt_w
    $error("rst_ctrl_gen: CNT_W too narrow for LOCK_FILTER/STRETCH_CYCLES");
  end

  logic rel_q;
  logic lock_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rel_sync (
    .clk_i (clk),
    .clr_i (clr),
    .d_i   (1'b0),
    .q_o   (rel_q)
  );

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk_i (clk),
    .clr_i (clr),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] stretch_cnt_q, stretch_cnt_d;
  logic             lock_lost_q, lock_lost_d;
  logic             rst_out_q, rst_n_out_q, ready_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= ST_ASSERT;
      lock_cnt_q    <= '0;
      stretch_cnt_q <= '0;
      lock_lost_q   <= 1'b0;
      rst_out_q     <= 1'b1;
      rst_n_out_q   <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      lock_lost_q   <= lock_lost_d;
      rst_out_q     <= (state_d != ST_RUN);
      rst_n_out_q   <= (state_d == ST_RUN);
      ready_q       <= (state_d == ST_RUN);
    end
  end

  // Same-edge priority: lock loss beats ext_rst_req beats counter progress.
  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    stretch_cnt_d = stretch_cnt_q;
    lock_lost_d   = lock_lost_q;
    case (state_q)
      ST_ASSERT: begin
        if (!rel_q) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
          state_d       = ST_STRETCH;
          lock_cnt_d    = '0;
          stretch_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      ST_STRETCH: begin
        if (!lock_s) begin
          state_d       = ST_WAIT_LOCK;
          lock_cnt_d    = '0;
          stretch_cnt_d = '0;
        end else if (ext_rst_req) begin
          stretch_cnt_d = '0;
        end else if (stretch_cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
          state_d       = ST_RUN;
          stretch_cnt_d = '0;
        end else begin
          stretch_cnt_d = stretch_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          lock_cnt_d  = '0;
          lock_lost_d = 1'b1;
        end else if (ext_rst_req) begin
          state_d       = ST_STRETCH;
          stretch_cnt_d = '0;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  assign rst_out   = rst_out_q;
  assign rst_n_out = rst_n_out_q;
  assign ready     = ready_q;
  assign rst_state = state_q;
  assign lock_lost = lock_lost_q;

endmodule
